// File: rtl/mmio_io_ctrl_if.sv
// CPU-side I/O bus between MemOrIO and the I/O controller.
// Latency: none, wires only; the controller registers rdata one cycle after io_read.
// Backpressure: none, every io_read/io_write strobe completes in one cycle.
interface mmio_io_ctrl_if;
    logic        io_read;
    logic        io_write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output io_read,
        output io_write,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  io_read,
        input  io_write,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/LED/button controller: SW, LED, STATUS (read-to-clear), BLINK (LED_BLINK_EN).
// Latency: read 1 cycle, write-to-leds 1 cycle, switches 2 cycles, press-to-pending 2+DEBOUNCE_CYCLES+1.
// Backpressure: none, accesses complete in a single cycle; a STATUS read never drops a concurrent press.
module mmio_io_ctrl #(
    parameter int SW_WIDTH          = 16,
    parameter int LED_WIDTH         = 16,
    parameter int DEBOUNCE_CYCLES   = 100000,
    parameter int BLINK_HALF_PERIOD = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_io_ctrl_if.slave        bus,
    input  logic [SW_WIDTH-1:0]  switches,
    input  logic                 comfirm_button,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 confirm_pending
);

    // Counter sized so DEBOUNCE_CYCLES=1 still gets a legal 1-bit counter.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_SW     = 2'd0;
    localparam logic [1:0] REG_LED    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BLINK  = 2'd3;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_WAIT_HIGH = 2'd1,
        DB_HIGH      = 2'd2,
        DB_WAIT_LOW  = 2'd3
    } db_state_t;

    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic                 btn_meta_q, btn_sync_q;
    db_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 press_evt;
    logic                 db_level;
    logic                 pending_q, pending_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          rd_word;
    logic [1:0]           sel;
    logic                 wr_led, wr_blink, rd_status;

    assign sel       = bus.addr[3:2];
    assign wr_led    = bus.io_write && (sel == REG_LED);
    assign wr_blink  = bus.io_write && (sel == REG_BLINK);
    assign rd_status = bus.io_read && (sel == REG_STATUS);

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= comfirm_button;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce FSM state and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next state: the level only flips after CNT_MAX+1 stable samples; press_evt marks the rising commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            DB_LOW: begin
                if (btn_sync_q) begin
                    state_d = DB_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_HIGH: begin
                if (!btn_sync_q) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = DB_HIGH;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_HIGH: begin
                if (!btn_sync_q) begin
                    state_d = DB_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_LOW: begin
                if (btn_sync_q) begin
                    state_d = DB_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign db_level = (state_q == DB_HIGH) || (state_q == DB_WAIT_LOW);

    // Sticky press flag: a new press wins over a same-cycle STATUS read so no event is lost.
    always_comb begin
        pending_d = pending_q;
        if (press_evt) begin
            pending_d = 1'b1;
        end else if (rd_status) begin
            pending_d = 1'b0;
        end
    end

    // Pending flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // LED register write decode.
    always_comb begin
        led_d = led_q;
        if (wr_led) begin
            led_d = bus.wdata[LED_WIDTH-1:0];
        end
    end

    // LED register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

`ifdef LED_BLINK_EN
    localparam int PH_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(BLINK_HALF_PERIOD - 1);

    logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic                 phase_q, phase_d;
    logic [LED_WIDTH-1:0] mask_q, mask_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic                 unused_cfg;

    // Blink phase, mask and LED drive next state; leds_d uses next-state values to keep write latency at 1.
    always_comb begin
        ph_cnt_d = ph_cnt_q + PH_W'(1);
        phase_d  = phase_q;
        if (ph_cnt_q == PH_MAX) begin
            ph_cnt_d = '0;
            phase_d  = ~phase_q;
        end
        mask_d = mask_q;
        if (wr_blink) begin
            mask_d = bus.wdata[LED_WIDTH-1:0];
        end
        leds_d = led_d ^ (mask_d & {LED_WIDTH{phase_d}});
    end

    // Blink state and registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_cnt_q <= '0;
            phase_q  <= 1'b0;
            mask_q   <= '0;
            leds_q   <= '0;
        end else begin
            ph_cnt_q <= ph_cnt_d;
            phase_q  <= phase_d;
            mask_q   <= mask_d;
            leds_q   <= leds_d;
        end
    end

    assign leds       = leds_q;
    assign unused_cfg = ^{bus.addr[1:0], bus.wdata};
`else
    logic [LED_WIDTH-1:0] mask_q;
    logic                 unused_cfg;

    // No blink hardware: BLINK reads as zero and its writes fall away.
    assign mask_q     = '0;
    assign leds       = led_q;
    assign unused_cfg = ^{bus.addr[1:0], bus.wdata, wr_blink, (BLINK_HALF_PERIOD > 0)};
`endif

    // Read mux over pre-write register values.
    always_comb begin
        rd_word = '0;
        case (sel)
            REG_SW:     rd_word[SW_WIDTH-1:0]  = sw_sync_q;
            REG_LED:    rd_word[LED_WIDTH-1:0] = led_q;
            REG_STATUS: rd_word[1:0]           = {db_level, pending_q};
            REG_BLINK:  rd_word[LED_WIDTH-1:0] = mask_q;
            default:    rd_word = '0;
        endcase
        rdata_d = bus.io_read ? rd_word : rdata_q;
    end

    // Read data register, held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign confirm_pending = pending_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed register/debounce/reset steps plus random traffic against a behavioural model.
// Latency: inputs driven and outputs sampled on the falling edge, so every check sees settled post-edge values.
// Backpressure: none; all waits are fixed cycle counts so the run always reaches its summary.
module tb_mmio_io_ctrl;
    localparam int DEB  = 4;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switches;
    logic        btn;
    logic [15:0] leds;
    logic        pend;

    mmio_io_ctrl_if bus();

    mmio_io_ctrl #(
        .SW_WIDTH(16),
        .LED_WIDTH(16),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF_PERIOD(HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .switches(switches),
        .comfirm_button(btn),
        .leds(leds),
        .confirm_pending(pend)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] led_m;
    logic [15:0] sw_m;
    logic        pend_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        bus.addr    = a;
        bus.io_read = 1'b1;
        @(negedge clk);
        bus.io_read = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus.addr     = a;
        bus.wdata    = d;
        bus.io_write = 1'b1;
        @(negedge clk);
        bus.io_write = 1'b0;
    endtask

    // Button high for len cycles from idle; a press is committed iff it survives
    // the 2-cycle synchroniser and DEB stable samples, i.e. len >= DEB+1, seen DEB+3 cycles after the rise.
    task automatic pulse(input int len);
        bit pressed;
        pressed = (len >= DEB + 1);
        btn = 1'b1;
        for (int c = 1; c <= len + 14; c++) begin
            @(negedge clk);
            if (c == len) btn = 1'b0;
            if (c == DEB + 2) chk("press_before", {31'b0, pend}, {31'b0, pend_m});
            if (c == DEB + 3) begin
                if (pressed) pend_m = 1'b1;
                chk("press_at", {31'b0, pend}, {31'b0, pend_m});
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          op;
        int          len;
        rst          = 1'b1;
        switches     = '0;
        btn          = 1'b0;
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        led_m        = '0;
        sw_m         = '0;
        pend_m       = 1'b0;

        #1;
        chk("rst_leds", {16'b0, leds}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_pending", {31'b0, pend}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Switch sampling through the synchroniser.
        switches = 16'hA5C3;
        sw_m     = 16'hA5C3;
        repeat (3) @(negedge clk);
        do_read(4'h0);
        chk("sw_read", bus.rdata, 32'h0000A5C3);

        // LED write, upper data bits discarded.
        do_write(4'h4, 32'hFFFF1234);
        led_m = 16'h1234;
        chk("led_drive", {16'b0, leds}, 32'h00001234);
        do_read(4'h4);
        chk("led_read", bus.rdata, 32'h00001234);

        // Unimplemented/disabled BLINK and write to RO registers.
        do_read(4'hC);
        chk("blink_rd0", bus.rdata, 32'h0);
        do_write(4'h0, 32'hFFFF_FFFF);
        do_write(4'h8, 32'hFFFF_FFFF);
        chk("ro_write_leds", {16'b0, leds}, {16'b0, led_m});

        // 3-cycle glitch never commits.
        pulse(3);
        chk("glitch_pending", {31'b0, pend}, 32'h0);

        // Clean 10-cycle press with back-to-back STATUS reads while held.
        btn = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 10) btn = 1'b0;
            if (c == 6) chk("press10_c6", {31'b0, pend}, 32'h0);
            if (c == 7) begin
                chk("press10_c7", {31'b0, pend}, 32'h1);
                bus.addr    = 4'h8;
                bus.io_read = 1'b1;
            end
            if (c == 8) begin
                chk("status_first", bus.rdata, 32'h3);
                chk("status_clears", {31'b0, pend}, 32'h0);
            end
            if (c == 9) begin
                bus.io_read = 1'b0;
                chk("status_second", bus.rdata, 32'h2);
            end
        end

        // STATUS read landing on the press-event cycle.
        btn = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 12) btn = 1'b0;
            if (c == DEB + 2) begin
                bus.addr    = 4'h8;
                bus.io_read = 1'b1;
            end
            if (c == DEB + 3) begin
                bus.io_read = 1'b0;
                chk("simul_rdata", bus.rdata, 32'h0);
                chk("simul_pending", {31'b0, pend}, 32'h1);
            end
        end
        do_read(4'h8);
        chk("simul_drain", bus.rdata, 32'h1);
        pend_m = 1'b0;

        // Random register traffic against the model.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            d  = $urandom;
            case (op)
                0: begin
                    do_write(4'h4, d);
                    led_m = d[15:0];
                    chk("rnd_led_w", {16'b0, leds}, {16'b0, led_m});
                end
                1: begin
                    do_read(4'h4 | 4'($urandom_range(0, 3)));
                    chk("rnd_led_r", bus.rdata, {16'b0, led_m});
                end
                2: begin
                    switches = d[15:0];
                    sw_m     = d[15:0];
                    repeat (3) @(negedge clk);
                    do_read(4'h0);
                    chk("rnd_sw_r", bus.rdata, {16'b0, sw_m});
                end
                3: begin
                    do_write(4'hC, d);
                    do_read(4'hC);
`ifdef LED_BLINK_EN
                    chk("rnd_blink_r", bus.rdata, {16'b0, d[15:0]});
                    do_write(4'hC, 32'h0);
`else
                    chk("rnd_blink_r", bus.rdata, 32'h0);
`endif
                end
                4: begin
                    bus.addr     = 4'h4;
                    bus.wdata    = d;
                    bus.io_read  = 1'b1;
                    bus.io_write = 1'b1;
                    @(negedge clk);
                    bus.io_read  = 1'b0;
                    bus.io_write = 1'b0;
                    chk("rnd_rw_old", bus.rdata, {16'b0, led_m});
                    led_m = d[15:0];
                    chk("rnd_rw_leds", {16'b0, leds}, {16'b0, led_m});
                end
                default: begin
                    do_write(($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, d);
                    chk("rnd_ro_leds", {16'b0, leds}, {16'b0, led_m});
                    chk("rnd_ro_pend", {31'b0, pend}, {31'b0, pend_m});
                end
            endcase
        end

        // Random-length button pulses; each followed by a STATUS read-to-clear.
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 10);
            pulse(len);
            do_read(4'h8);
            chk("rnd_status", bus.rdata, {31'b0, pend_m});
            pend_m = 1'b0;
            chk("rnd_cleared", {31'b0, pend}, 32'h0);
        end

        // Asynchronous reset mid-debounce, button held through release.
        do_write(4'h4, 32'h0000_0055);
        do_read(4'h4);
        chk("pre_rst_rdata", bus.rdata, 32'h55);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_leds", {16'b0, leds}, 32'h0);
        chk("arst_rdata", bus.rdata, 32'h0);
        chk("arst_pending", {31'b0, pend}, 32'h0);
        led_m  = '0;
        sw_m   = '0;
        pend_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= DEB + 3; c++) begin
            @(negedge clk);
            if (c == DEB + 2) chk("held_c6", {31'b0, pend}, 32'h0);
            if (c == DEB + 3) chk("held_c7", {31'b0, pend}, 32'h1);
        end
        do_read(4'h8);
        chk("held_status", bus.rdata, 32'h3);
        repeat (12) @(negedge clk);
        chk("held_once", {31'b0, pend}, 32'h0);
        btn = 1'b0;
        repeat (12) @(negedge clk);

`ifdef LED_BLINK_EN
        begin
            logic [15:0] prev;
            int          run;
            int          edges;
            do_write(4'h4, 32'h0000_00F0);
            do_write(4'hC, 32'h0000_000F);
            prev  = leds;
            run   = 0;
            edges = 0;
            for (int c = 0; c < 5 * HALF; c++) begin
                @(negedge clk);
                run++;
                chk("blink_val", {31'b0, (leds == 16'h00F0) || (leds == 16'h00FF)}, 32'h1);
                if (leds != prev) begin
                    if (edges > 0) chk("blink_run", run, HALF);
                    edges++;
                    run  = 0;
                    prev = leds;
                end
            end
            chk("blink_toggled", {31'b0, edges >= 3}, 32'h1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the minisys 32 CPU, sitting between MemOrIO and the board pins. It replaces the bare switch/LED passthrough with registered LED outputs, synchronised switch sampling, and a debounced confirm button that raises a sticky read-to-clear event flag. The CPU sees four word registers selected by the low address bits whenever IORead/IOWrite is asserted.

## Interface
- `SW_WIDTH`, default 16: number of switch inputs (1..32).
- `LED_WIDTH`, default 16: number of LED outputs (1..32).
- `DEBOUNCE_CYCLES`, default 100000: clock cycles the synchronised button must be stable before its debounced level changes (>=1).
- `BLINK_HALF_PERIOD`, default 5000000: cycles per blink phase (only used with `LED_BLINK_EN`).
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `switches` input SW_WIDTH: raw board switches.
- `comfirm_button` input 1: raw confirm button, active-high.
- `io_read` input 1: CPU I/O read strobe, one cycle per access.
- `io_write` input 1: CPU I/O write strobe, one cycle per access.
- `addr` input 4: byte offset within the I/O window; bits [3:2] select the register, bits [1:0] ignored.
- `wdata` input 32: write data.
- `rdata` output 32: registered read data.
- `leds` output LED_WIDTH: LED drive.
- `confirm_pending` output 1: sticky debounced-press flag.

## Operation
- Register map:
  - 0x0 SW (RO): synchronised switches, zero-extended.
  - 0x4 LED (RW): LED register; writes take `wdata[LED_WIDTH-1:0]`.
  - 0x8 STATUS (RO, read-to-clear): bit0 = pending, bit1 = current debounced button level, other bits 0.
  - 0xC BLINK (RW, macro-gated): blink mask.
- Writes to RO registers are ignored.
- Switches pass through a 2-flop synchroniser, and the button through its own 2-flop synchroniser.
- Debounce FSM has states LOW, WAIT_HIGH, HIGH and WAIT_LOW.
  - LOW -> WAIT_HIGH when the synchronised button is 1; the counter clears.
  - In WAIT_HIGH, the counter increments while the input is 1. The FSM returns to LOW if the input drops. It enters HIGH when the counter reaches DEBOUNCE_CYCLES-1.
  - HIGH/WAIT_LOW mirror this for release.
  - The debounced level is 1 in HIGH and WAIT_LOW.
- The LOW/WAIT_HIGH -> HIGH transition is the press event and sets `pending`. Release does not set `pending`.
- A STATUS read clears `pending` after its value is sampled into `rdata`.
- If a press event coincides with a STATUS read, `pending` stays 1. The read returns the old value and the new event is not lost.
- If `io_read` and `io_write` are both asserted, the write takes effect and the read returns the pre-write value.
- Unused `addr` decode is impossible (4 registers); upper `addr` bits are the caller's responsibility.

## Timing
- Reset values: `rdata`=0, `leds`=0, `confirm_pending`=0, LED reg=0, BLINK mask=0, FSM=LOW, counters=0, synchronisers=0.
- Read latency is 1 cycle: `rdata` is valid the cycle after `io_read` and held until the next read.
- Write latency is 1 cycle: `leds` reflects the write on the cycle after `io_write`.
- Switch-to-SW-register latency is 2 cycles.
- Press-to-pending latency: a clean press is visible on `confirm_pending` 2 + DEBOUNCE_CYCLES + 1 cycles after the input rises.
- Reset mid-debounce returns the FSM to LOW immediately. A button held through reset release produces exactly one press event, after full debounce.

## Configuration
- `LED_BLINK_EN` defined:
  - A free-running phase counter toggles a `phase` bit every BLINK_HALF_PERIOD cycles.
  - `leds` = LED reg ^ (BLINK mask & {LED_WIDTH{phase}}), registered.
  - BLINK is read/write at 0xC. `phase` resets to 0.
- `LED_BLINK_EN` undefined:
  - No phase counter and no mask register.
  - 0xC reads 0 and writes are ignored.
  - `leds` = LED reg.

## Test plan
- Reset: assert `rst` mid-simulation. Required: `leds`=0, `rdata`=0, `confirm_pending`=0 immediately, without waiting for a clock edge.
- Switch read: `switches`=16'hA5C3, wait 3 cycles, read 0x0. Required: `rdata`=32'h0000A5C3 the next cycle.
- LED write/read: write 0x4 with 32'hFFFF1234. Required: `leds`=16'h1234 the next cycle, and reading 0x4 returns 32'h00001234.
- Debounce (DEBOUNCE_CYCLES=4):
  - A 3-cycle glitch must leave `pending`=0.
  - A 10-cycle press must set `pending`=1 exactly 7 cycles after the rise.
  - A STATUS read then returns 32'h3 and clears `pending`. A second read returns 32'h2 while the button is still held.
- Simultaneous event: time a STATUS read on the exact cycle of the press event. Required: read returns bit0=0 and `pending` remains 1.
- `LED_BLINK_EN` (BLINK_HALF_PERIOD=8): set LED=16'h00F0 and BLINK=16'h000F. Required: `leds` alternates 16'h00F0/16'h00FF every 8 cycles. Without the macro, reading 0xC returns 0.
